// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte sources,
// with per-packet ownership lock and a sticky timeout flag.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   ack,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_end,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int            CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [1:0]    OWNER_RST = 2'(NREQ - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_END = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic            lock_q, lock_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic            pick_valid;
  logic [1:0]      pick_idx;
  logic            grant_valid;
  logic [1:0]      grant_idx;

  logic [7:0]      req_byte [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  function automatic logic [1:0] rr_index(input logic [1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return 2'(s);
  endfunction

  // Scan from the farthest candidate inward so the one nearest owner+1 wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = owner_q;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[rr_index(owner_q, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_index(owner_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    cnt_d       = cnt_q;
    err_d       = err_q & ~err_clr;
    ack_d       = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = '0;
    grant_valid = 1'b0;
    grant_idx   = owner_q;

    case (state_q)
      IDLE: begin
        if (lock_q && !req[owner_q]) begin
          // Lock holder walked away: drop the lock, arbitrate normally next cycle.
          lock_d = 1'b0;
        end else if (!tx_busy) begin
          if (lock_q) begin
            grant_valid = 1'b1;
            grant_idx   = owner_q;
          end else if (pick_valid) begin
            grant_valid = 1'b1;
            grant_idx   = pick_idx;
          end
        end

        if (grant_valid) begin
          state_d          = WAIT_END;
          owner_d          = grant_idx;
          lock_d           = req_lock[grant_idx];
          cnt_d            = '0;
          ack_d[grant_idx] = 1'b1;
          tx_start_d       = 1'b1;
          tx_data_d        = req_byte[grant_idx];
        end
      end

      WAIT_END: begin
        if (tx_end) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Timeout set takes priority over a same-cycle err_clr.
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_RST;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign owner    = owner_q;
  assign busy     = (state_q == WAIT_END);
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner cases,
// and randomized traffic against a transaction-style reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_lock = '0;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        tx_end = 1'b0;
  logic [1:0]  owner;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_lock(req_lock),
    .ack(ack), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_end(tx_end), .owner(owner), .busy(busy), .err(err), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who owns the line, whether a packet lock is held,
  // whether a byte is in flight and since which cycle.
  int         m_owner = NREQ - 1;
  bit         m_lock  = 1'b0;
  bit         m_xfer  = 1'b0;
  int         m_start = 0;
  int         m_cycle = 0;
  bit         m_err   = 1'b0;
  logic [3:0] e_ack   = '0;
  bit         e_start = 1'b0;
  logic [7:0] e_data  = '0;
  int         grant_log[$];
  int         data_log[$];

  // Simple transmitter emulation: tx_end returned tx_delay cycles after start.
  int tx_delay = 0;
  int tx_cnt   = 0;
  bit tx_force_end = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int cand[$];
    int g;
    bit timeout;
    g       = -1;
    timeout = 1'b0;
    e_ack   = '0;
    e_start = 1'b0;
    e_data  = '0;
    if (reset) begin
      m_owner = NREQ - 1;
      m_lock  = 1'b0;
      m_xfer  = 1'b0;
      m_err   = 1'b0;
    end else begin
      if (!m_xfer) begin
        if (m_lock && !req[m_owner]) begin
          m_lock = 1'b0;
        end else if (!tx_busy) begin
          if (m_lock) cand.push_back(m_owner);
          else for (int k = 1; k <= NREQ; k++) cand.push_back((m_owner + k) % NREQ);
          foreach (cand[j]) if (g < 0 && req[cand[j]]) g = cand[j];
        end
        if (g >= 0) begin
          e_ack[g] = 1'b1;
          e_start  = 1'b1;
          e_data   = req_data[8*g +: 8];
          m_owner  = g;
          m_lock   = req_lock[g];
          m_xfer   = 1'b1;
          m_start  = m_cycle + 1;
          grant_log.push_back(g);
          data_log.push_back(int'(e_data));
        end
      end else if (tx_end) begin
        m_xfer = 1'b0;
      end else if (m_cycle + 1 - m_start == TIMEOUT) begin
        timeout = 1'b1;
        m_xfer  = 1'b0;
        m_lock  = 1'b0;
      end
      if (timeout) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    m_cycle++;
  endtask

  task automatic step();
    tx_end = tx_force_end || (tx_cnt == 1);
    model_step();
    @(posedge clk);
    #1;
    if (tx_cnt > 0) tx_cnt--;
    if (reset) tx_cnt = 0;
    else if (e_start && tx_delay > 0) tx_cnt = tx_delay + 1;
    check("ack", ack, e_ack);
    check("tx_start", tx_start, e_start);
    check("tx_data", tx_data, e_data);
    check("owner", owner, m_owner);
    check("busy", busy, m_xfer);
    check("err", err, m_err);
  endtask

  task automatic run_until_idle();
    for (int i = 0; i < 100 && m_xfer; i++) step();
    check("idle_reached", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic       tbusy;
    logic       tend;
    logic [3:0] x_ack;
    logic       x_start;
    logic [7:0] x_data;
    logic [1:0] x_owner;
    logic       x_busy;
  } vec_t;

  vec_t tbl[14];
  int   exp1[4] = '{'h10, 'h21, 'h32, 'h43};
  int   exp2[4] = '{2, 2, 2, 0};
  int   exp2d[4] = '{'hA0, 'hA1, 'hA2, 'h10};

  initial begin
    int n2, idle_cnt, bad, cnt;
    bit got;

    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1};
    tbl[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[3]  = '{4'b1010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 8'h21, 2'd1, 1'b1};
    tbl[4]  = '{4'b1010, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    tbl[5]  = '{4'b1010, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h43, 2'd3, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};
    tbl[7]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};
    tbl[8]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[10] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[11] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};

    // Reset state
    req_data = 32'h43322110;
    do_reset();
    check("rst_owner", owner, 3);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);

    // Vector table
    foreach (tbl[i]) begin
      req          = tbl[i].req;
      req_lock     = tbl[i].lock;
      tx_busy      = tbl[i].tbusy;
      tx_force_end = tbl[i].tend;
      step();
      check("tbl_ack", ack, tbl[i].x_ack);
      check("tbl_start", tx_start, tbl[i].x_start);
      check("tbl_data", tx_data, tbl[i].x_data);
      check("tbl_owner", owner, tbl[i].x_owner);
      check("tbl_busy", busy, tbl[i].x_busy);
    end
    req = '0; req_lock = '0; tx_busy = 1'b0; tx_force_end = 1'b0;

    // All four requesting: service order 0,1,2,3
    do_reset();
    tx_delay = 10;
    grant_log.delete();
    data_log.delete();
    req = 4'hF;
    for (int i = 0; i < 200 && grant_log.size() < 4; i++) begin
      step();
      req &= ~e_ack;
    end
    check("t1_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check("t1_order", grant_log[i], i);
      check("t1_data", data_log[i], exp1[i]);
    end

    // Locked three-byte packet from requester 2 while requester 0 waits
    run_until_idle();
    grant_log.delete();
    data_log.delete();
    n2 = 0;
    req_data[23:16] = 8'hA0;
    req_lock = 4'b0100;
    req = 4'b0100;
    for (int i = 0; i < 300 && grant_log.size() < 4; i++) begin
      step();
      if (e_ack[2]) begin
        n2++;
        req[0] = 1'b1;
        if (n2 < 3) begin
          req_data[23:16] = 8'(8'hA0 + n2);
          req_lock[2] = (n2 < 2);
        end else begin
          req[2] = 1'b0;
        end
      end
      if (e_ack[0]) req[0] = 1'b0;
    end
    check("t2_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check("t2_order", grant_log[i], exp2[i]);
      check("t2_data", data_log[i], exp2d[i]);
    end
    req_lock = '0;

    // Lock holder 1 drops req: one idle cycle, then requester 2
    run_until_idle();
    grant_log.delete();
    req = 4'b0010;
    req_lock = 4'b0010;
    for (int i = 0; i < 50 && grant_log.size() < 1; i++) step();
    check("t3_lock_grant", owner, 1);
    req = 4'b0101;
    req_lock = '0;
    idle_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      if (ack != 0) got = 1'b1;
      else if (!busy) idle_cnt++;
    end
    check("t3_gap", idle_cnt, 2);
    check("t3_ack", ack, 4'b0100);
    req = '0;

    // tx_busy stall
    run_until_idle();
    req = 4'b0001;
    tx_busy = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (tx_start || ack != 0) bad++;
    end
    check("t4_stall", bad, 0);
    tx_busy = 1'b0;
    step();
    check("t4_start", tx_start, 1);
    check("t4_ack", ack, 4'b0001);
    req = '0;

    // Timeout, clear, and clear coincident with a second timeout
    run_until_idle();
    tx_delay = 0;
    req = 4'b0001;
    step();
    check("t5_start", tx_start, 1);
    req = '0;
    cnt = 0;
    for (int i = 0; i < 40 && !err; i++) begin
      step();
      cnt++;
    end
    check("t5_err_delay", cnt, TIMEOUT);
    check("t5_idle", busy, 0);
    req = 4'b0010;
    step();
    check("t5_regrant", ack, 4'b0010);
    req = '0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_clr", err, 0);
    repeat (TIMEOUT - 2) step();
    check("t5_pre_err", err, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_set_wins", err, 1);
    check("t5_idle2", busy, 0);

    // Reset in WAIT_END, then stray tx_end in IDLE
    tx_delay = 10;
    req = 4'b0001;
    for (int i = 0; i < 20 && ack == 0; i++) step();
    req = '0;
    step();
    step();
    check("t6_in_xfer", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_ack", ack, 0);
    check("t6_start", tx_start, 0);
    check("t6_data", tx_data, 0);
    check("t6_owner", owner, 3);
    check("t6_busy", busy, 0);
    check("t6_err", err, 0);
    tx_force_end = 1'b1;
    step();
    tx_force_end = 1'b0;
    check("t6_stray_busy", busy, 0);
    check("t6_stray_owner", owner, 3);
    step();
    check("t6_stray_start", tx_start, 0);

    // Randomized traffic against the reference model
    tx_delay = 0;
    for (int i = 0; i < 3000; i++) begin
      req          = 4'($urandom);
      req_data     = $urandom;
      req_lock     = 4'($urandom);
      tx_busy      = ($urandom_range(0, 3) == 0);
      tx_force_end = ($urandom_range(0, 7) == 0);
      err_clr      = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    tx_force_end = 1'b0;
    err_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter between up to four on-chip byte sources. It sits between the requesters and the UART control/transmit path. It owns the transmitter's `tx_start`/`tx_data` inputs and consumes its `tx_busy`/`tx_end` status. It serialises one byte at a time, supports a lock for multi-byte packets, and flags a sticky error if the transmitter fails to complete.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..4.
- `TIMEOUT`, default 4096: maximum cycles spent in WAIT_END before abort; must be ≥ 2.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `req`  in  NREQ: per-requester "byte valid"; held high until acknowledged.
- `req_data`  in  8*NREQ: byte for requester i at bits [8i+7:8i].
- `req_lock`  in  NREQ: sampled at grant; 1 keeps ownership for the next byte.
- `ack`  out  NREQ: one-cycle pulse, byte of requester i accepted.
- `tx_start`  out  1: one-cycle start pulse to the transmitter.
- `tx_data`  out  8: byte to transmit; 0 when `tx_start` is low.
- `tx_busy`  in  1: transmitter busy.
- `tx_end`  in  1: one-cycle transmit-complete pulse.
- `owner`  out  2: index of the last granted requester.
- `busy`  out  1: high in any state other than IDLE.
- `err`  out  1: sticky timeout flag.
- `err_clr`  in  1: clears `err`.

## Operation
- FSM states are IDLE and WAIT_END. `busy` = (state == WAIT_END).
- IDLE grant condition: `tx_busy` == 0 and at least one eligible `req`.
- Eligible set when no lock is held: all `req` bits. Search starts at (`owner`+1) mod NREQ and wraps. After reset `owner` = NREQ-1, so requester 0 has highest priority first.
- Eligible set when a lock is held by requester k: only `req[k]`.
- Lock release: if `req[k]` is low in IDLE, the lock is released that cycle and there is no grant that cycle. Normal arbitration resumes the next cycle.
- On grant of requester g, all registered and applied at the next edge:
  - `tx_start` = 1 and `tx_data` = `req_data[g]`.
  - `ack[g]` = 1 and `owner` = g.
  - lock = `req_lock[g]`.
  - timeout counter cleared; state goes to WAIT_END.
- WAIT_END:
  - `req` is ignored.
  - On `tx_end`, go to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1: set `err`, release the lock, go to IDLE.
- `tx_end` seen in IDLE is ignored.
- `err`:
  - `err_clr` clears it.
  - If `err_clr` and a timeout occur in the same cycle, set wins.
  - Arbitration continues while `err` = 1.
- Reset values: every output 0, except `owner` = NREQ-1. Lock cleared, counter 0, state IDLE.
- Reset asserted mid-transfer returns to IDLE next edge. No `ack` or `tx_start` is generated.
- Requester bits at index ≥ NREQ do not exist; `owner` never exceeds NREQ-1.

## Timing
- `req` sampled high at edge T (IDLE, `tx_busy` low) → `tx_start`, `tx_data` and `ack` are high during cycle T+1 only.
- Requester may drop `req` or change `req_data` from cycle T+2. The arbiter does not resample until it is back in IDLE.
- `tx_end` high in cycle E → IDLE in E+1. Earliest next `tx_start` is in E+2.
- Minimum spacing between `tx_start` pulses is 2 cycles plus the transmitter's busy time.
- `tx_busy` high in IDLE stalls the grant with no ack. Grant occurs the cycle after `tx_busy` falls.
- Timeout: `err` rises exactly TIMEOUT cycles after the `tx_start` cycle, with no `tx_end` in between.

## Test plan
- Reset, then `req` = 4'b1111 with bytes 0x10/0x21/0x32/0x43 and `tx_end` returned 10 cycles after each start → `tx_data` order is 0x10, 0x21, 0x32, 0x43 and `ack` order is bits 0, 1, 2, 3. Each `ack` coincides with its `tx_start`.
- Requester 2 sends three bytes with `req_lock` = 1, 1, 0 while requester 0 holds `req` high → order is 2, 2, 2, 0. `owner` = 2 throughout the packet.
- Lock held by requester 1 and `req[1]` dropped in IDLE → one idle cycle with no grant, then requester 2 is granted (pointer continues from owner 1).
- `tx_busy` forced high for 20 cycles with `req[0]` high → no `tx_start`/`ack` during those cycles. Grant in the cycle after `tx_busy` falls.
- TIMEOUT = 16 and `tx_end` never returned → `err` = 1 exactly 16 cycles after `tx_start`, FSM back in IDLE, next request granted. Then `err_clr` pulse → `err` = 0. `err_clr` coincident with a second timeout → `err` stays 1.
- Reset asserted in WAIT_END, and `tx_end` injected while IDLE → all outputs 0 and `owner` = NREQ-1 after reset. The stray `tx_end` causes no state change.
